// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl - data memory for the load/store stage with a request/response
// handshake. One request outstanding at a time; byte/half/word/dword accesses
// with byte-lane stores and zero- or sign-extended loads. Misaligned,
// out-of-range and oversize accesses return a fault and never touch memory.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready registered)
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 dword
//   req_signed            sign-extend narrow loads
//   adr                   byte address
//   datain                store data (low 8<<req_size bits used)
//   rsp_valid/rsp_ready   response handshake (rsp_valid registered)
//   rsp_rdata             load result, 0 for stores and faults
//   rsp_fault             access rejected
// ---------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] datain,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  localparam int BW    = DATA_W / 8;
  localparam int OFF_W = $clog2(BW);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        cnt_q;

  // Storage holds (contents XOR word index): power-up all-zero storage
  // therefore reads back as word i = i without any initialisation pass.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [OFF_W-1:0]  offset_s;
  logic [IDX_W-1:0]  idx_s;
  logic [2:0]        align_mask_s;
  logic              fault_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] size_mask_s;
  logic              sign_bit_s;
  logic [DATA_W-1:0] load_s;
  logic [7:0]        be_base_s;
  logic [BW-1:0]     be_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] wr_word_d;

  // req_ready_q is only high in IDLE, so this is the acceptance condition.
  assign accept_s   = req_valid && req_ready_q;
  assign word_idx_s = adr >> OFF_W;
  assign offset_s   = adr[OFF_W-1:0];
  assign idx_s      = word_idx_s[IDX_W-1:0];

  // Fault classification of the presented request.
  always_comb begin
    case (req_size)
      2'b00:   align_mask_s = 3'b000;
      2'b01:   align_mask_s = 3'b001;
      2'b10:   align_mask_s = 3'b011;
      default: align_mask_s = 3'b111;
    endcase
    fault_s = ((req_size == 2'b11) && (DATA_W == 32)) ||
              ((3'(offset_s) & align_mask_s) != 3'b000) ||
              (word_idx_s >= ADDR_W'(DEPTH));
  end

  // Load path: lane extraction, then zero or sign extension.
  always_comb begin
    rd_word_s   = mem_q[idx_s] ^ DATA_W'(idx_s);
    shifted_s   = rd_word_s >> {offset_s, 3'b000};
    // A full-width shift yields zero, so the mask is all ones for full-width
    // loads and sign extension becomes a no-op there.
    size_mask_s = ~({DATA_W{1'b1}} << (7'd8 << req_size));
    case (req_size)
      2'b00:   sign_bit_s = shifted_s[7];
      2'b01:   sign_bit_s = shifted_s[15];
      2'b10:   sign_bit_s = shifted_s[31];
      default: sign_bit_s = shifted_s[DATA_W-1];
    endcase
    if (req_signed && sign_bit_s) begin
      load_s = (shifted_s & size_mask_s) | ~size_mask_s;
    end else begin
      load_s = shifted_s & size_mask_s;
    end
  end

  // Store path: byte enables and lane merge with the current word.
  always_comb begin
    case (req_size)
      2'b00:   be_base_s = 8'h01;
      2'b01:   be_base_s = 8'h03;
      2'b10:   be_base_s = 8'h0F;
      default: be_base_s = 8'hFF;
    endcase
    be_s    = BW'(be_base_s << offset_s);
    wdata_s = datain << {offset_s, 3'b000};
    wr_word_d = rd_word_s;
    for (int b = 0; b < BW; b++) begin
      if (be_s[b]) begin
        wr_word_d[8*b +: 8] = wdata_s[8*b +: 8];
      end else begin
        wr_word_d[8*b +: 8] = rd_word_s[8*b +: 8];
      end
    end
  end

  // Store commit at the acceptance edge; storage is not touched by reset.
  always_ff @(posedge clk) begin
    if (accept_s && req_we && !fault_s) begin
      mem_q[idx_s] <= wr_word_d ^ DATA_W'(idx_s);
    end
  end

  // Handshake FSM with registered ready/valid and response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_fault_q <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      case (state_q)
        ST_RST: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        ST_IDLE: begin
          if (accept_s) begin
            req_ready_q <= 1'b0;
            rsp_fault_q <= fault_s;
            rsp_rdata_q <= (req_we || fault_s) ? {DATA_W{1'b0}} : load_s;
            if (LATENCY == 1) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              // Countdown of LATENCY-2 more edges after this one.
              state_q <= ST_WAIT;
              cnt_q   <= 2'(LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_RST;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          cnt_q       <= 2'd0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for dmem_ctrl. Three instances cover the configurations of interest:
//   0: DATA_W=64, LATENCY=1   1: DATA_W=64, LATENCY=3   2: DATA_W=32, LATENCY=2
// Expected responses come from a byte-addressed memory model per instance.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
  logic        we, sgn;
  logic [1:0]  size;
  logic [63:0] adr, din;
  logic [63:0] rdata_a, rdata_b;
  logic [31:0] rdata_c;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mb [3][2048];

  dmem_ctrl #(.DATA_W(64), .DEPTH(256), .ADDR_W(64), .LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(we), .req_size(size), .req_signed(sgn), .adr(adr), .datain(din),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rdata_a),
    .rsp_fault(rsp_fault[0]));

  dmem_ctrl #(.DATA_W(64), .DEPTH(256), .ADDR_W(64), .LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(we), .req_size(size), .req_signed(sgn), .adr(adr), .datain(din),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rdata_b),
    .rsp_fault(rsp_fault[1]));

  dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(64), .LATENCY(2)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(we), .req_size(size), .req_signed(sgn), .adr(adr), .datain(din[31:0]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rdata_c),
    .rsp_fault(rsp_fault[2]));

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic int wb_of(int i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic logic [63:0] rdata_of(int i);
    if (i == 0) return rdata_a;
    else if (i == 1) return rdata_b;
    else return {32'h0, rdata_c};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: byte array, little-endian lanes, faults by rule.
  task automatic model_access(input int inst, input bit w, input logic [1:0] sz,
                              input bit sg, input logic [63:0] a, input logic [63:0] d,
                              output logic [63:0] er, output logic ef);
    int wb, n, base;
    logic [63:0] wmask;
    wb = wb_of(inst);
    n  = 1 << sz;
    er = 64'h0;
    ef = (sz == 2'b11 && wb == 4) || ((a % 64'(n)) != 64'h0) || (a >= 64'(256 * wb));
    if (!ef) begin
      base = int'(a);
      if (w) begin
        for (int k = 0; k < n; k++) mb[inst][base + k] = d[8*k +: 8];
      end else begin
        for (int k = 0; k < n; k++) er = er | (64'(mb[inst][base + k]) << (8 * k));
        wmask = (wb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (sg && n < wb && er[8*n - 1]) er = er | (~((64'h1 << (8 * n)) - 64'h1) & wmask);
      end
    end
  endtask

  // One complete transaction; entered and left on a falling edge.
  task automatic do_access(input int inst, input bit w, input logic [1:0] sz, input bit sg,
                           input logic [63:0] a, input logic [63:0] d, input int stall,
                           output logic [63:0] got_r, output logic got_f);
    logic [63:0] er;
    logic        ef;
    int          lat;
    lat = lat_of(inst);
    check_eq($sformatf("ready_idle[%0d]", inst), req_ready[inst], 1'b1);
    model_access(inst, w, sz, sg, a, d, er, ef);
    we = w; size = sz; sgn = sg; adr = a; din = d;
    req_valid[inst] = 1'b1;
    @(negedge clk);
    req_valid[inst] = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      check_eq($sformatf("valid_lat%0d[%0d]", c, inst), rsp_valid[inst], (c == lat));
      check_eq($sformatf("ready_busy[%0d]", inst), req_ready[inst], 1'b0);
    end
    got_r = rdata_of(inst);
    got_f = rsp_fault[inst];
    check_eq($sformatf("rdata[%0d] a=%0h", inst, a), got_r, er);
    check_eq($sformatf("fault[%0d] a=%0h", inst, a), got_f, ef);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq($sformatf("hold_valid[%0d]", inst), rsp_valid[inst], 1'b1);
      check_eq($sformatf("hold_rdata[%0d]", inst), rdata_of(inst), er);
      check_eq($sformatf("hold_fault[%0d]", inst), rsp_fault[inst], ef);
      check_eq($sformatf("hold_ready[%0d]", inst), req_ready[inst], 1'b0);
    end
    rsp_ready[inst] = 1'b1;
    @(negedge clk);
    rsp_ready[inst] = 1'b0;
    check_eq($sformatf("valid_drop[%0d]", inst), rsp_valid[inst], 1'b0);
    check_eq($sformatf("ready_back[%0d]", inst), req_ready[inst], 1'b1);
  endtask

  initial begin
    logic [63:0] r;
    logic        f;
    logic [63:0] er;
    logic        ef;
    rst_n = 1'b0;
    req_valid = 3'b000; rsp_ready = 3'b000;
    we = 1'b0; sgn = 1'b0; size = 2'b00; adr = 64'h0; din = 64'h0;
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 256; w++)
        for (int k = 0; k < wb_of(i); k++)
          mb[i][w * wb_of(i) + k] = (k == 0) ? 8'(w) : 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_ready", req_ready[i], 1'b0);
      check_eq("rst_valid", rsp_valid[i], 1'b0);
      check_eq("rst_rdata", rdata_of(i), 64'h0);
      check_eq("rst_fault", rsp_fault[i], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_eq("rel_ready", req_ready[i], 1'b1);

    // 64-bit, latency 1
    do_access(0, 1'b0, 2'b11, 1'b0, 64'h28, 64'h0, 0, r, f);
    check_eq("tp_dword28", r, 64'h5);
    do_access(0, 1'b1, 2'b00, 1'b0, 64'h11, 64'hF0, 0, r, f);
    do_access(0, 1'b0, 2'b00, 1'b1, 64'h11, 64'h0, 1, r, f);
    check_eq("tp_sbyte11", r, 64'hFFFF_FFFF_FFFF_FFF0);
    do_access(0, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0, r, f);
    check_eq("tp_dword10", r, 64'h0000_0000_0000_F002);
    do_access(0, 1'b0, 2'b01, 1'b0, 64'h03, 64'h0, 0, r, f);
    check_eq("tp_mis_fault", f, 1'b1);
    check_eq("tp_mis_rdata", r, 64'h0);
    do_access(0, 1'b0, 2'b11, 1'b0, 64'h800, 64'h0, 0, r, f);
    check_eq("tp_oor_fault", f, 1'b1);
    do_access(0, 1'b1, 2'b01, 1'b0, 64'h03, 64'hFFFF, 0, r, f);
    do_access(0, 1'b1, 2'b11, 1'b0, 64'h800, 64'hDEAD_BEEF, 0, r, f);
    do_access(0, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 0, r, f);
    check_eq("tp_word0_kept", r, 64'h0);
    do_access(0, 1'b0, 2'b11, 1'b0, 64'h7F8, 64'h0, 0, r, f);
    check_eq("tp_word255_kept", r, 64'hFF);

    // 64-bit, latency 3, response held off for 5 cycles
    do_access(1, 1'b0, 2'b11, 1'b0, 64'h18, 64'h0, 5, r, f);
    check_eq("tp_lat3_rdata", r, 64'h3);

    // Reset while a store waits out its latency
    check_eq("rstw_ready", req_ready[1], 1'b1);
    model_access(1, 1'b1, 2'b11, 1'b0, 64'h38, 64'h1234, er, ef);
    we = 1'b1; size = 2'b11; sgn = 1'b0; adr = 64'h38; din = 64'h1234;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_valid0", rsp_valid[1], 1'b0);
    check_eq("rstw_ready0", req_ready[1], 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rstw_valid", rsp_valid[1], 1'b0);
      check_eq("rstw_ready", req_ready, 3'b000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstw_rel_ready", req_ready, 3'b111);
    check_eq("rstw_rel_valid", rsp_valid[1], 1'b0);
    do_access(1, 1'b0, 2'b11, 1'b0, 64'h38, 64'h0, 0, r, f);
    check_eq("tp_word7_kept", r, 64'h1234);

    // 32-bit, latency 2
    do_access(2, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 0, r, f);
    check_eq("tp_w32_dword_fault", f, 1'b1);
    do_access(2, 1'b1, 2'b01, 1'b0, 64'h6, 64'h8001, 0, r, f);
    do_access(2, 1'b0, 2'b01, 1'b0, 64'h6, 64'h0, 0, r, f);
    check_eq("tp_w32_uhalf", r, 64'h8001);

    // Randomised traffic against the model
    for (int it = 0; it < 200; it++) begin
      int inst, wb, n, idx, off;
      logic [1:0]  sz;
      logic [63:0] a;
      inst = $urandom_range(0, 2);
      wb   = wb_of(inst);
      sz   = 2'($urandom_range(0, 3));
      n    = 1 << sz;
      idx  = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 270) : $urandom_range(0, 15);
      off  = $urandom_range(0, wb - 1);
      if ($urandom_range(0, 3) != 0) off = off & ~(n - 1);
      a = 64'(idx * wb + off);
      if ($urandom_range(0, 19) == 0) a = {$urandom, $urandom};
      do_access(inst, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                {$urandom, $urandom}, $urandom_range(0, 3), r, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the ARM CPU's load/store stage, replacing the flat single-width array with one that has a request/response handshake. Supports byte, halfword, word and doubleword accesses with byte-lane writes and zero- or sign-extended loads. Read latency is configurable and response backpressure is supported. Misaligned, out-of-range or oversize accesses are reported as faults instead of corrupting memory.

## Interface
- DATA_W, 64: memory word width in bits. Legal values are 32 or 64.
- DEPTH, 256: number of DATA_W words.
- ADDR_W, 64: byte-address width.
- LATENCY, 1: cycles from request acceptance to the first cycle of rsp_valid. Legal range is 1..4.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- req_signed  in  1  load sign-extends when 1. Ignored for stores and for full-width loads.
- adr  in  ADDR_W  byte address.
- datain  in  DATA_W  store data. Only the low (8<<req_size) bits are used.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  load result. It is 0 for stores and for faults.
- rsp_fault  out  1  access rejected.

## Operation
- States:
  - RST: req_ready 0. Entered on reset.
  - IDLE: req_ready 1.
  - WAIT: latency countdown.
  - RESP: rsp_valid 1.
- State transitions:
  - RST→IDLE on the first clk edge with rst_n high.
  - IDLE→RESP (LATENCY=1) or IDLE→WAIT (LATENCY>1) on req_valid && req_ready.
  - WAIT→RESP when the countdown reaches 0.
  - RESP→IDLE on rsp_valid && rsp_ready.
- Address decoding: word index = adr >> log2(DATA_W/8). Byte offset = adr[log2(DATA_W/8)-1:0].
- Faults are checked at acceptance, in this priority order:
  - size 11 with DATA_W=32;
  - offset not a multiple of (1<<req_size);
  - word index ≥ DEPTH.
- A faulted access: no memory write, rsp_fault=1, rsp_rdata=0.
- Store behaviour: committed to the addressed byte lanes at the acceptance edge. Other lanes of the word are unchanged.
- Load behaviour: data is snapshotted at the acceptance edge and registered for the response.
  - Bytes are extracted from the addressed offset.
  - The result is zero-extended, or sign-extended when req_signed=1, to DATA_W.
- Response outputs (rsp_rdata, rsp_fault) hold stable throughout RESP.
- Memory contents: word i initialised to i at time zero. Contents are not affected by rst_n.
- Only one request is outstanding at a time. No request is accepted while in WAIT or RESP.

## Timing
- Reset values: state RST, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_fault 0, countdown 0.
- Acceptance at edge N: rsp_valid rises after edge N+LATENCY-1 and stays high until the edge where rsp_ready=1.
- req_ready returns to 1 in the cycle after the response handshake.
- Minimum issue interval is LATENCY+1 cycles.
- req_ready, rsp_valid and all response outputs are registered. None depends combinationally on inputs.
- Reset mid-operation: any WAIT or RESP transaction is discarded and rsp_valid drops immediately. A store already accepted before reset remains committed.
- Load to the address of the immediately preceding store returns the stored data.

## Test plan
- Reset release, then a dword load at adr 0x28 (DATA_W=64) → after 1 cycle: rsp_valid=1, rsp_rdata=5, rsp_fault=0.
- Store byte 0xF0 at adr 0x11, then signed byte load at 0x11 → rsp_rdata=0xFFFF_FFFF_FFFF_FFF0. Dword load at 0x10 → 0x0000_0000_0000_F002.
- Half load at adr 0x03 → rsp_fault=1, rsp_rdata=0. Dword load at adr 0x800 (index 256) → fault. A store at either address leaves memory unchanged.
- LATENCY=3 with rsp_ready held low for 5 cycles:
  - rsp_valid rises 3 cycles after acceptance;
  - rsp_rdata and rsp_fault stay stable and req_ready stays 0 until the handshake;
  - req_ready is 1 one cycle later.
- rst_n asserted while in WAIT following a store of 0x1234 to word 7:
  - rsp_valid is never raised;
  - req_ready is 0 during reset and 1 one edge after release;
  - a later load of word 7 returns 0x1234.
- DATA_W=32: a size 11 access → fault. An unsigned half load at adr 0x6 after storing 0x8001 there → 0x0000_8001.
